// File: rtl/proc_param_multiciclo_pkg.sv
// proc_param_pkg: opcodes, FSM states and ALU selects shared by the multi-cycle core.
package proc_param_pkg;
    localparam logic [2:0] OP_MV  = 3'd0;
    localparam logic [2:0] OP_MVI = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_SLT = 3'd6;
    localparam logic [2:0] OP_RSV = 3'd7;
    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;
    // Ordered so that an ALU opcode minus OP_ADD gives its select.
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;
endpackage

// File: rtl/proc_param_multiciclo_if.sv
// proc_param_if: control/data bundle of the multi-cycle core.
// Flag signals exist only when STATUS_FLAGS_EN is defined.
interface proc_param_if #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
);
    localparam int REG_W = $clog2(NREG);
    logic                 run;
    logic [3+2*REG_W-1:0] ir;
    logic [DATA_W-1:0]    din;
    logic                 done;
    logic                 busy;
    logic [DATA_W-1:0]    bus_out;
    logic [REG_W-1:0]     dbg_sel;
    logic [DATA_W-1:0]    dbg_data;
`ifdef STATUS_FLAGS_EN
    logic flag_z, flag_n, flag_c;
    modport master (output run, ir, din, dbg_sel, input done, busy, bus_out, dbg_data, flag_z, flag_n, flag_c);
    modport slave  (input run, ir, din, dbg_sel, output done, busy, bus_out, dbg_data, flag_z, flag_n, flag_c);
`else
    modport master (output run, ir, din, dbg_sel, input done, busy, bus_out, dbg_data);
    modport slave  (input run, ir, din, dbg_sel, output done, busy, bus_out, dbg_data);
`endif
endinterface

// File: rtl/proc_param_multiciclo_alu.sv
// alu_param: combinational add/sub/and/or/slt with carry (NOT borrow for sub).
module alu_param
    import proc_param_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  alu_op_t           i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_y,
    output logic              o_c
);
    logic              w_sub;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W:0]   w_sum;
    assign w_sub = i_op == ALU_SUB;
    assign w_b   = w_sub ? ~i_b : i_b;
    assign w_sum = {1'b0, i_a} + {1'b0, w_b} + {{DATA_W{1'b0}}, w_sub};
    assign o_y   = (i_op == ALU_ADD || w_sub) ? w_sum[DATA_W-1:0] :
                   (i_op == ALU_AND) ? (i_a & i_b) :
                   (i_op == ALU_OR)  ? (i_a | i_b) :
                   {{(DATA_W-1){1'b0}}, $signed(i_a) < $signed(i_b)};
    assign o_c   = (i_op == ALU_ADD || w_sub) & w_sum[DATA_W];
endmodule

// File: rtl/proc_param_multiciclo.sv
// proc_param_multiciclo: multi-cycle core with NREG registers, A/G, shared bus and IDLE/T1/T2/T3 FSM.
// Define STATUS_FLAGS_EN to add Z/N/C flags captured on the G write.
module proc_param_multiciclo
    import proc_param_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input logic         clock,
    input logic         resetn,
    proc_param_if.slave p
);
    localparam int REG_W = $clog2(NREG);
    localparam int IR_W  = 3 + 2*REG_W;
    state_t            r_state, w_next;
    logic [DATA_W-1:0] r_reg [NREG];
    logic [DATA_W-1:0] r_a, r_g, w_bus, w_alu_y;
    logic [IR_W-1:0]   r_ir;
    logic [2:0]        w_op;
    logic [REG_W-1:0]  w_rx, w_ry;
    logic              w_is_alu, w_alu_c, w_done, w_reg_we, w_a_we, w_g_we;
    alu_op_t           w_alu_op;
    assign w_op     = r_ir[IR_W-1 -: 3];
    assign w_rx     = r_ir[2*REG_W-1 -: REG_W];
    assign w_ry     = r_ir[REG_W-1:0];
    assign w_is_alu = !(w_op inside {OP_MV, OP_MVI, OP_RSV});
    assign w_alu_op = w_is_alu ? alu_op_t'(w_op - OP_ADD) : ALU_ADD;

    always_ff @(posedge clock or negedge resetn)
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;

    always_comb
        w_next = (r_state == IDLE) ? (p.run ? T1 : IDLE) :
                 (r_state == T1 && w_is_alu) ? T2 :
                 (r_state == T2) ? T3 : IDLE;

    always_comb begin
        w_a_we   = r_state == T1 && w_is_alu;
        w_g_we   = r_state == T2;
        w_reg_we = (r_state == T1 && (w_op == OP_MV || w_op == OP_MVI)) || r_state == T3;
        w_done   = (r_state == T1 && !w_is_alu) || r_state == T3;
        w_bus    = (r_state == T1) ? ((w_op == OP_MV)  ? r_reg[w_ry] :
                                      (w_op == OP_MVI) ? p.din :
                                      w_is_alu         ? r_reg[w_rx] : '0) :
                   (r_state == T2) ? r_reg[w_ry] :
                   (r_state == T3) ? r_g : '0;
    end

    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) r_reg[i] <= '0;
            r_a  <= '0;
            r_g  <= '0;
            r_ir <= '0;
        end else begin
            if (r_state == IDLE && p.run) r_ir <= p.ir;
            if (w_a_we)   r_a <= w_bus;
            if (w_g_we)   r_g <= w_alu_y;
            if (w_reg_we) r_reg[w_rx] <= w_bus;
        end

    alu_param #(.DATA_W(DATA_W)) u_alu (
        .i_op(w_alu_op),
        .i_a (r_a),
        .i_b (w_bus),
        .o_y (w_alu_y),
        .o_c (w_alu_c)
    );

    assign p.done     = w_done;
    assign p.busy     = r_state != IDLE;
    assign p.bus_out  = w_bus;
    assign p.dbg_data = r_reg[p.dbg_sel];

`ifdef STATUS_FLAGS_EN
    logic r_fz, r_fn, r_fc;
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            r_fz <= 1'b0;
            r_fn <= 1'b0;
            r_fc <= 1'b0;
        end else if (w_g_we) begin
            r_fz <= w_alu_y == '0;
            r_fn <= w_alu_y[DATA_W-1];
            r_fc <= w_alu_c;
        end
    assign p.flag_z = r_fz;
    assign p.flag_n = r_fn;
    assign p.flag_c = r_fc;
`else
    logic w_unused_c;
    assign w_unused_c = w_alu_c;
`endif
endmodule
